// File: rtl/fixed_mac_vec.sv
// Streaming fixed-point vector MAC: per-beat lane dot product, accumulated per packet, resized to WIO.WFO.
// Optional macro FIXED_MAC_VEC_ROUND_EN selects round-half-up instead of truncation on dropped LSBs.
module fixed_mac_vec #(
  parameter int LANES = 4,
  parameter int WI1   = 4,
  parameter int WF1   = 8,
  parameter int WI2   = 3,
  parameter int WF2   = 5,
  parameter int WIO   = 15,
  parameter int WFO   = 30,
  parameter int GUARD = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES*(WI1+WF1)-1:0]   in_a_data,
  input  logic [LANES*(WI2+WF2)-1:0]   in_b_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  output logic [WIO+WFO-1:0]           out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         sat_en,
  output logic                         out_overflow,
  output logic                         out_underflow
);

  localparam int AW   = WI1 + WF1;
  localparam int BW   = WI2 + WF2;
  localparam int PW   = AW + BW;
  localparam int PF   = WF1 + WF2;
  localparam int SW   = PW + $clog2(LANES);
  localparam int ACCW = SW + GUARD;
  localparam int OW   = WIO + WFO;
  localparam int SH   = WFO - PF;
  localparam int LSH  = (SH > 0) ? SH : 0;
  localparam int RSH  = (SH < 0) ? -SH : 0;
  localparam int EW0  = ACCW + LSH + 1;
  localparam int EW   = (EW0 > OW + 1) ? EW0 : OW + 1;

  localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

`ifdef FIXED_MAC_VEC_ROUND_EN
  localparam logic signed [EW-1:0] HALF = (RSH > 0) ? (EW'(1) << ((RSH > 0) ? RSH - 1 : 0)) : '0;
`endif

  typedef enum logic {IDLE, ACC} state_t;

  state_t                   state;
  logic                     rdy;
  logic                     stall;

  logic [LANES*AW-1:0]      a_r;
  logic [LANES*BW-1:0]      b_r;
  logic                     v1, l1;
  logic signed [PW-1:0]     prod_c [LANES];
  logic signed [PW-1:0]     prod_r [LANES];
  logic                     v2, l2;
  logic signed [SW-1:0]     sum_c;
  logic signed [SW-1:0]     sum_r;
  logic                     v3, l3;
  logic signed [ACCW-1:0]   acc_next;
  logic signed [ACCW-1:0]   acc;
  logic                     v4, l4;

  logic signed [EW-1:0]     shl;
  logic signed [EW-1:0]     scaled;
  logic                     ovf, unf;
  logic [OW-1:0]            res;

  assign stall    = out_valid && !out_ready;
  assign in_ready = rdy && !stall;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_c[i] = PW'(signed'(a_r[i*AW +: AW])) * PW'(signed'(b_r[i*BW +: BW]));
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_c = sum_c + SW'(prod_r[i]);
    end
  end

  always_comb begin
    if (state == IDLE) acc_next = ACCW'(sum_r);
    else               acc_next = acc + ACCW'(sum_r);
  end

  // Align the accumulator binary point to WFO, then range-check the widened value.
  always_comb begin
    shl = EW'(acc) <<< LSH;
`ifdef FIXED_MAC_VEC_ROUND_EN
    scaled = (shl + HALF) >>> RSH;
`else
    scaled = shl >>> RSH;
`endif
    ovf = !scaled[EW-1] && (|scaled[EW-2:OW-1]);
    unf = scaled[EW-1] && !(&scaled[EW-2:OW-1]);
    res = scaled[OW-1:0];
    if (sat_en && ovf)      res = OMAX;
    else if (sat_en && unf) res = OMIN;
  end

  // S3 is two registers deep (lane sum, then accumulator), giving a 4-cycle last-beat-to-result latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy           <= 1'b0;
      state         <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      v1            <= 1'b0;
      l1            <= 1'b0;
      prod_r        <= '{default: '0};
      v2            <= 1'b0;
      l2            <= 1'b0;
      sum_r         <= '0;
      v3            <= 1'b0;
      l3            <= 1'b0;
      acc           <= '0;
      v4            <= 1'b0;
      l4            <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (!stall) begin
        v1 <= in_valid && rdy;
        l1 <= in_last;
        if (in_valid && rdy) begin
          a_r <= in_a_data;
          b_r <= in_b_data;
        end
        v2 <= v1;
        l2 <= l1;
        if (v1) prod_r <= prod_c;
        v3 <= v2;
        l3 <= l2;
        if (v2) sum_r <= sum_c;
        v4 <= v3;
        l4 <= l3;
        if (v3) begin
          acc   <= acc_next;
          state <= l3 ? IDLE : ACC;
        end
        if (v4 && l4) begin
          out_valid     <= 1'b1;
          out_data      <= res;
          out_overflow  <= ovf;
          out_underflow <= unf;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_mac_vec.sv
// Bench for fixed_mac_vec: three 2-lane instances (default, WIO=4, WFO=4) fed the same stream, checked via a scoreboard.
module tb_fixed_mac_vec;

  typedef struct {
    longint s;
    bit     sat;
    bit     chk;
    int     t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_a;
  logic [15:0] in_b;
  logic        in_valid, in_last, out_ready, sat_en;
  logic        r0, r1, r2;
  logic [44:0] d0_data;
  logic [33:0] d1_data;
  logic [18:0] d2_data;
  logic        d0_valid, d1_valid, d2_valid;
  logic        d0_ov, d0_un, d1_ov, d1_un, d2_ov, d2_un;

  int     n_assert = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  longint acc_s    = 0;
  bit     lat_en   = 1'b1;
  bit     seen     = 1'b0;
  bit     stall_done;
  exp_t   sb[$];
  exp_t   e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_mac_vec #(.LANES(2)) d0 (
    .clk(clk), .reset(reset), .in_a_data(in_a), .in_b_data(in_b),
    .in_valid(in_valid), .in_ready(r0), .in_last(in_last),
    .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
    .sat_en(sat_en), .out_overflow(d0_ov), .out_underflow(d0_un));

  fixed_mac_vec #(.LANES(2), .WIO(4)) d1 (
    .clk(clk), .reset(reset), .in_a_data(in_a), .in_b_data(in_b),
    .in_valid(in_valid), .in_ready(r1), .in_last(in_last),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .sat_en(sat_en), .out_overflow(d1_ov), .out_underflow(d1_un));

  fixed_mac_vec #(.LANES(2), .WFO(4)) d2 (
    .clk(clk), .reset(reset), .in_a_data(in_a), .in_b_data(in_b),
    .in_valid(in_valid), .in_ready(r2), .in_last(in_last),
    .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
    .sat_en(sat_en), .out_overflow(d2_ov), .out_underflow(d2_un));

  // s is the packet sum in units of 2^-13; result packed as {overflow, underflow, data}.
  function automatic logic [65:0] model(input longint s, input int ow, input int sh, input bit sat);
    longint v, mx, mn;
    bit ov, un;
    logic [63:0] d;
    if (sh >= 0) v = s <<< sh;
    else begin
`ifdef FIXED_MAC_VEC_ROUND_EN
      v = (s + (longint'(1) <<< (-sh - 1))) >>> (-sh);
`else
      v = s >>> (-sh);
`endif
    end
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    ov = v > mx;
    un = v < mn;
    if (sat && ov)      v = mx;
    else if (sat && un) v = mn;
    d = 64'(v) & ((64'd1 << ow) - 64'd1);
    return {ov, un, d};
  endfunction

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input int a0, input int a1, input int b0, input int b1, input bit last);
    logic [11:0] a0v, a1v;
    logic [7:0]  b0v, b1v;
    int n;
    @(negedge clk);
    a0v = 12'(a0); a1v = 12'(a1);
    b0v = 8'(b0);  b1v = 8'(b1);
    in_a = {a1v, a0v};
    in_b = {b1v, b0v};
    in_valid = 1'b1;
    in_last  = last;
    #1;
    n = 0;
    while (!r0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!r0) begin
      n_assert++; n_fail++;
      $display("FAIL in_ready_timeout: observed in_ready=0 required 1");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "handshake bound expired");
    end
    acc_s += longint'(a0 * b0 + a1 * b1);
    if (last) begin
      sb.push_back('{acc_s, sat_en, lat_en, cyc + 1});
      acc_s = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check("drain", 66'(sb.size()), 66'(0));
    @(negedge clk);
  endtask

  always begin
    @(negedge clk); #2;
    if (!reset) seen = 1'b0;
    else if (d0_valid) begin
      check("sb_nonempty", 66'(sb.size() != 0), 66'(1));
      if (sb.size() != 0) begin
        e = sb[0];
        if (!seen) begin
          seen = 1'b1;
          if (e.chk) check("latency", 66'(cyc - e.t), 66'(4));
        end
        check("d1_valid", 66'(d1_valid), 66'(1));
        check("d2_valid", 66'(d2_valid), 66'(1));
        check("d0_result", {d0_ov, d0_un, 64'(d0_data)}, model(e.s, 45, 17, e.sat));
        check("d1_result", {d1_ov, d1_un, 64'(d1_data)}, model(e.s, 34, 17, e.sat));
        check("d2_result", {d2_ov, d2_un, 64'(d2_data)}, model(e.s, 19, -9, e.sat));
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_a = '0; in_b = '0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; sat_en = 1'b1;

    // asynchronous reset, before any clock edge
    #2 reset = 1'b0;
    #2;
    check("rst_out", {d0_valid, d0_ov, d0_un, 64'(d0_data)}, '0);
    check("rst_in_ready", 66'(r0), 66'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #2 check("in_ready_before_edge", 66'(r0), 66'(0));
    @(posedge clk); #1;
    check("in_ready_after_edge", 66'(r0), 66'(1));

    // single beat 1.5*2.0 = 3.0
    send(384, 0, 64, 0, 1'b1);
    idle(); drain();

    // three-beat zero-sum packet, then an immediate single-beat 2.0
    send(256, 256, 32, -32, 1'b0);
    send(256, 256, 32, -32, 1'b0);
    send(256, 256, 32, -32, 1'b1);
    send(512, 0, 32, 0, 1'b1);
    idle(); drain();

    // back-pressure for 5 cycles while a long packet streams
    @(negedge clk);
    out_ready  = 1'b0;
    stall_done = 1'b0;
    fork
      begin
        int k;
        k = 0;
        while (!d0_valid && k < 200) begin @(negedge clk); k++; end
        check("stall_valid_seen", 66'(d0_valid), 66'(1));
        for (int i = 0; i < 5; i++) begin
          #2 check("stall_in_ready", 66'(r0), 66'(0));
          @(negedge clk);
        end
        out_ready  = 1'b1;
        stall_done = 1'b1;
      end
    join_none
    send(256, 128, 48, -64, 1'b1);
    lat_en = 1'b0;
    for (int i = 0; i < 8; i++) send(100 * i - 300, 50 + 7 * i, 10 - 3 * i, i - 5, i == 7);
    idle();
    begin
      int n;
      n = 0;
      while (!stall_done && n < 200) begin @(negedge clk); n++; end
      check("stall_released", 66'(stall_done), 66'(1));
    end
    drain();
    lat_en = 1'b1;

    // range errors: +60.0 and -32.0, saturating then wrapping
    for (int s = 1; s >= 0; s--) begin
      sat_en = 1'(s);
      send(1920, 1920, 64, 64, 1'b0);
      send(1920, 1920, 64, 64, 1'b1);
      send(-2048, -2048, 64, 64, 1'b1);
      idle(); drain();
    end
    sat_en = 1'b1;

    // 3 x 0.03125: exercises dropped-LSB handling on the WFO=4 instance
    send(8, 0, 32, 0, 1'b0);
    send(8, 0, 32, 0, 1'b0);
    send(8, 0, 32, 0, 1'b1);
    idle(); drain();

    // random packets of 1..3 beats
    for (int p = 0; p < 4; p++) begin
      int len;
      len = int'($urandom_range(1, 3));
      for (int j = 0; j < len; j++)
        send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, j == len - 1);
    end
    idle(); drain();

    // reset mid-packet discards the partial accumulation
    send(256, 0, 32, 0, 1'b0);
    send(256, 0, 32, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #3 reset = 1'b0;
    acc_s = 0;
    #1;
    check("midrst_out", {d0_valid, d0_ov, d0_un, 64'(d0_data)}, '0);
    check("midrst_in_ready", 66'(r0), 66'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_after", 66'(r0), 66'(1));
    send(256, 0, 32, 0, 1'b1);
    idle(); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_mac_vec.md
FIXED_MAC_VEC -- requirements
Module: fixed_mac_vec

Interface
REQ-001 SHALL provide parameter LANES, default 4, meaning elements per input beat (1..16).
REQ-002 SHALL provide parameters WI1/WF1, default 4/8, meaning A integer/fraction bits (signed, two's complement).
REQ-003 SHALL provide parameters WI2/WF2, default 3/5, meaning B integer/fraction bits.
REQ-004 SHALL provide parameters WIO/WFO, default 15/30, meaning output integer/fraction bits.
REQ-005 SHALL provide parameter GUARD, default 16, meaning accumulator guard bits above the lane-sum width.
REQ-006 SHALL provide port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL provide port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL provide in_a_data, input, LANES*(WI1+WF1), A vector; lane 0 in the LSBs.
REQ-009 SHALL provide in_b_data, input, LANES*(WI2+WF2), B vector; lane 0 in the LSBs.
REQ-010 SHALL provide in_valid (input, 1), in_ready (output, 1) and in_last (input, 1, final beat of a packet).
REQ-011 SHALL provide out_data, output, WIO+WFO, resized dot-product result.
REQ-012 SHALL provide out_valid (output, 1) and out_ready (input, 1).
REQ-013 SHALL provide sat_en, input, 1: 1 = saturate on range error, 0 = wrap.
REQ-014 SHALL provide out_overflow and out_underflow, output, 1 each, qualified by out_valid.

Function
REQ-015 A beat SHALL transfer only on in_valid && in_ready.
REQ-016 Pipeline: S1 registers inputs, S2 registers LANES signed products (WI1+WI2 . WF1+WF2), S3 registers the lane sum (+clog2(LANES) bits) and the accumulator.
REQ-017 The accumulator SHALL be LANES-sum width + GUARD. Its first beat of a packet SHALL load the sum, and later beats SHALL add it. Overflow inside the accumulator SHALL wrap silently.
REQ-018 Packet state: IDLE (after reset) -> ACC on the first beat. ACC -> IDLE when the in_last beat leaves S3, with the result written to the output register.
REQ-019 Result SHALL appear with out_valid high exactly 4 cycles after the in_last handshake, absent stalls.
REQ-020 The output register SHALL hold out_data and flags stable while out_valid && !out_ready.
REQ-021 Global stall = out_valid && !out_ready. It SHALL freeze S1-S3 and force in_ready low. Otherwise in_ready SHALL be high.
REQ-022 Back-to-back packets SHALL be accepted with no bubble. A single-beat packet (first and last) SHALL be legal.
REQ-023 Resize fraction: if WFO >= WF1+WF2, zero-fill the LSBs; otherwise drop the LSBs per REQ-029.
REQ-024 out_overflow SHALL be 1 when the value exceeds the maximum WIO.WFO value. out_underflow SHALL be 1 when it is below the minimum.
REQ-025 With sat_en = 1, the output SHALL be clamped to max/min on a range error. With sat_en = 0, the output SHALL keep the low WIO+WFO bits.
REQ-026 out_valid SHALL clear on the cycle after an out_valid && out_ready handshake, unless a new result lands in that same cycle.

Reset
REQ-027 While reset is low, every register SHALL clear asynchronously: out_valid = 0, out_data = 0, out_overflow = 0, out_underflow = 0, in_ready = 0, accumulator = 0, packet state = IDLE.
REQ-028 A partial packet in flight SHALL be discarded. in_ready SHALL go high on the first clk edge after reset is released.

Configuration
REQ-029 Macro FIXED_MAC_VEC_ROUND_EN: when defined, dropped LSBs SHALL round half-up (add half an output LSB, then truncate), applied before range checking. When undefined, dropped LSBs SHALL truncate (floor), with no rounding adder.

Verification (LANES=2, defaults otherwise)
REQ-030 Single beat: A = {1.5, 0}, B = {2.0, 0}, in_last = 1 -> 4 cycles later out_data = 3.0 (0x0_C000_0000), both flags 0.
REQ-031 Three-beat packet of A = {1.0, 1.0}, B = {1.0, -1.0}, followed immediately by one beat A = {2.0, 0}, B = {1.0, 0} -> results 0.0 then 2.0 on consecutive out_valid cycles.
REQ-032 out_ready held low for 5 cycles while a second packet streams -> in_ready low for 5 cycles, first out_data stable, no beat lost, second result correct.
REQ-033 Set WIO = 4, sat_en = 1, sum = 60.0 -> out_data = max positive, out_overflow = 1. Same with sat_en = 0 -> wrapped low bits, out_overflow = 1.
REQ-034 Set WFO = 4 with product 0.03125 x 1 repeated 2 times (0.0625) plus 0.03125: ROUND_EN defined -> 0.125. ROUND_EN undefined -> 0.0625.
REQ-035 Assert reset mid-packet after 2 beats, release, send A = {1.0, 0}, B = {1.0, 0} single beat -> out_data = 1.0, no earlier contribution.
